acc_icb_master_arb: RTL and testbench

- Round-robin arbiter that shares the accelerator's single ICB master port (acc_icb_*) between NUM_REQ internal requesters, e.g. feature loader, weight loader and output writer.
- Forwards one requester's command per handshake and records that requester's index in an in-order outstanding FIFO.
- Routes each returning response to the requester at the FIFO head.
- Sits between the accelerator datapath engines and the acc_icb_* ports of the accelerator top.

---
 rtl/acc_arb_pkg.sv | 41 ++++
 rtl/acc_arb_id_fifo.sv | 48 ++++
 rtl/acc_icb_master_arb.sv | 152 +++++++++++++++
 tb/tb_acc_icb_master_arb.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_arb_pkg.sv
// Shared types and the round-robin pick helper for the accelerator ICB master arbiter.
package acc_arb_pkg;

    localparam int ICB_AW    = 32;
    localparam int ICB_DW    = 32;
    localparam int ICB_MW    = 4;
    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    typedef struct packed {
        logic              read;
        logic [ICB_AW-1:0] addr;
        logic [ICB_DW-1:0] wdata;
        logic [ICB_MW-1:0] wmask;
    } icb_cmd_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping at n (n <= MAX_REQ, ptr < n).
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                         input logic [MAX_IDX_W-1:0] ptr,
                                         input int                   n);
        rr_pick_t r;
        int       j;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= n) j = j - n;
            if (i < n && !r.found && valid[j[MAX_IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[MAX_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_arb_id_fifo.sv
// Register FIFO holding the requester index of every outstanding ICB command, oldest at head.
module acc_arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/acc_icb_master_arb.sv
// Round-robin share of the accelerator ICB master port between NUM_REQ engines, with in-order
// response routing. Define ACC_ICB_ARB_ERR_STICKY_EN to add per-requester sticky error flags.
module acc_icb_master_arb
    import acc_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int OUTS_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef ACC_ICB_ARB_ERR_STICKY_EN
    input  logic                    err_clr,
    output logic [NUM_REQ-1:0]      req_err_sticky,
`endif
    input  logic [NUM_REQ-1:0]      req_cmd_valid,
    output logic [NUM_REQ-1:0]      req_cmd_ready,
    input  logic [NUM_REQ-1:0]      req_cmd_read,
    input  logic [NUM_REQ*32-1:0]   req_cmd_addr,
    input  logic [NUM_REQ*32-1:0]   req_cmd_wdata,
    input  logic [NUM_REQ*4-1:0]    req_cmd_wmask,
    output logic [NUM_REQ-1:0]      req_rsp_valid,
    input  logic [NUM_REQ-1:0]      req_rsp_ready,
    output logic [31:0]             req_rsp_rdata,
    output logic                    req_rsp_err,
    output logic                    acc_icb_cmd_valid,
    input  logic                    acc_icb_cmd_ready,
    output logic                    acc_icb_cmd_read,
    output logic [31:0]             acc_icb_cmd_addr,
    output logic [31:0]             acc_icb_cmd_wdata,
    output logic [3:0]              acc_icb_cmd_wmask,
    input  logic                    acc_icb_rsp_valid,
    output logic                    acc_icb_rsp_ready,
    input  logic                    acc_icb_rsp_err,
    input  logic [31:0]             acc_icb_rsp_rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1; a
    // presented command (valid with its fields) must stay unchanged until it is accepted.

    logic               lock_q;
    logic [IDX_W-1:0]   locked_idx_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic               spurious_q;
    logic               spurious_unused;

    logic               fifo_full;
    logic               fifo_empty;
    logic [IDX_W-1:0]   head_idx;

    rr_pick_t           pick;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    icb_cmd_t           cmd_arr [NUM_REQ];
    icb_cmd_t           cmd_sel;
    logic               cmd_hs;
    logic               rsp_hs;

    // A locked grant overrides the round-robin search until its command is accepted.
    always_comb begin
        pick        = rr_pick(MAX_REQ'(req_cmd_valid), MAX_IDX_W'(rr_ptr_q), NUM_REQ);
        grant_idx   = lock_q ? locked_idx_q : IDX_W'(pick.idx);
        grant_valid = !rst && !fifo_full && (lock_q || pick.found);
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cmd_arr[i].read  = req_cmd_read[i];
            cmd_arr[i].addr  = req_cmd_addr[ICB_AW*i +: ICB_AW];
            cmd_arr[i].wdata = req_cmd_wdata[ICB_DW*i +: ICB_DW];
            cmd_arr[i].wmask = req_cmd_wmask[ICB_MW*i +: ICB_MW];
        end
        cmd_sel = cmd_arr[grant_idx];
    end

    always_comb begin
        req_cmd_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_cmd_ready[i] = grant_valid && (grant_idx == IDX_W'(i)) && acc_icb_cmd_ready;
        end
    end

    assign acc_icb_cmd_valid = grant_valid;
    assign acc_icb_cmd_read  = cmd_sel.read;
    assign acc_icb_cmd_addr  = cmd_sel.addr;
    assign acc_icb_cmd_wdata = cmd_sel.wdata;
    assign acc_icb_cmd_wmask = cmd_sel.wmask;
    assign cmd_hs            = grant_valid && acc_icb_cmd_ready;

    // With nothing outstanding the response port sinks whatever arrives.
    always_comb begin
        req_rsp_valid     = '0;
        acc_icb_rsp_ready = 1'b1;
        if (!rst && !fifo_empty) begin
            req_rsp_valid[head_idx] = acc_icb_rsp_valid;
            acc_icb_rsp_ready       = req_rsp_ready[head_idx];
        end
        rsp_hs = !rst && !fifo_empty && acc_icb_rsp_valid && acc_icb_rsp_ready;
    end

    assign req_rsp_rdata = acc_icb_rsp_rdata;
    assign req_rsp_err   = acc_icb_rsp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q       <= 1'b0;
            locked_idx_q <= '0;
            rr_ptr_q     <= '0;
            spurious_q   <= 1'b0;
        end else begin
            if (cmd_hs) begin
                lock_q   <= 1'b0;
                rr_ptr_q <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            end else if (grant_valid) begin
                lock_q       <= 1'b1;
                locked_idx_q <= grant_idx;
            end
            if (acc_icb_rsp_valid && fifo_empty) spurious_q <= 1'b1;
        end
    end

    assign spurious_unused = spurious_q;

    acc_arb_id_fifo #(
        .DEPTH (OUTS_DEPTH),
        .WIDTH (IDX_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_hs),
        .push_data (grant_idx),
        .pop       (rsp_hs),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_idx)
    );

`ifdef ACC_ICB_ARB_ERR_STICKY_EN
    // req_rsp_valid is one-hot on the head requester during a response handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_err_sticky <= '0;
        end else if (err_clr) begin
            req_err_sticky <= '0;
        end else if (rsp_hs && acc_icb_rsp_err) begin
            req_err_sticky <= req_err_sticky | req_rsp_valid;
        end
    end
`endif

endmodule

// File: tb/tb_acc_icb_master_arb.sv
// Directed bench for acc_icb_master_arb with cmd/rsp scoreboards; covers ACC_ICB_ARB_ERR_STICKY_EN when defined.
module tb_acc_icb_master_arb;

    localparam int NREQ = 3;
    localparam int CW   = NREQ + 1 + 32 + 32 + 4;
    localparam int RW   = NREQ + 1 + 32;

    logic               clk;
    logic               rst;
`ifdef ACC_ICB_ARB_ERR_STICKY_EN
    logic               err_clr;
    logic [NREQ-1:0]    req_err_sticky;
`endif
    logic [NREQ-1:0]    req_cmd_valid;
    logic [NREQ-1:0]    req_cmd_ready;
    logic [NREQ-1:0]    req_cmd_read;
    logic [NREQ*32-1:0] req_cmd_addr;
    logic [NREQ*32-1:0] req_cmd_wdata;
    logic [NREQ*4-1:0]  req_cmd_wmask;
    logic [NREQ-1:0]    req_rsp_valid;
    logic [NREQ-1:0]    req_rsp_ready;
    logic [31:0]        req_rsp_rdata;
    logic               req_rsp_err;
    logic               acc_icb_cmd_valid;
    logic               acc_icb_cmd_ready;
    logic               acc_icb_cmd_read;
    logic [31:0]        acc_icb_cmd_addr;
    logic [31:0]        acc_icb_cmd_wdata;
    logic [3:0]         acc_icb_cmd_wmask;
    logic               acc_icb_rsp_valid;
    logic               acc_icb_rsp_ready;
    logic               acc_icb_rsp_err;
    logic [31:0]        acc_icb_rsp_rdata;

    logic [CW-1:0] exp_cmd_q[$];
    logic [RW-1:0] exp_rsp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    acc_icb_master_arb #(.NUM_REQ(NREQ), .OUTS_DEPTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
`ifdef ACC_ICB_ARB_ERR_STICKY_EN
        .err_clr           (err_clr),
        .req_err_sticky    (req_err_sticky),
`endif
        .req_cmd_valid     (req_cmd_valid),
        .req_cmd_ready     (req_cmd_ready),
        .req_cmd_read      (req_cmd_read),
        .req_cmd_addr      (req_cmd_addr),
        .req_cmd_wdata     (req_cmd_wdata),
        .req_cmd_wmask     (req_cmd_wmask),
        .req_rsp_valid     (req_rsp_valid),
        .req_rsp_ready     (req_rsp_ready),
        .req_rsp_rdata     (req_rsp_rdata),
        .req_rsp_err       (req_rsp_err),
        .acc_icb_cmd_valid (acc_icb_cmd_valid),
        .acc_icb_cmd_ready (acc_icb_cmd_ready),
        .acc_icb_cmd_read  (acc_icb_cmd_read),
        .acc_icb_cmd_addr  (acc_icb_cmd_addr),
        .acc_icb_cmd_wdata (acc_icb_cmd_wdata),
        .acc_icb_cmd_wmask (acc_icb_cmd_wmask),
        .acc_icb_rsp_valid (acc_icb_rsp_valid),
        .acc_icb_rsp_ready (acc_icb_rsp_ready),
        .acc_icb_rsp_err   (acc_icb_rsp_err),
        .acc_icb_rsp_rdata (acc_icb_rsp_rdata)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Helpers
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rd, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
        req_cmd_read[i]          = rd;
        req_cmd_addr[32*i +: 32]  = a;
        req_cmd_wdata[32*i +: 32] = d;
        req_cmd_wmask[4*i +: 4]   = m;
        req_cmd_valid[i]         = 1'b1;
    endtask

    task automatic exp_cmd(input logic [2:0] oh, input logic rd, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
        exp_cmd_q.push_back({oh, rd, a, d, m});
    endtask

    task automatic exp_rsp(input logic [2:0] oh, input logic err, input logic [31:0] rdata);
        exp_rsp_q.push_back({oh, err, rdata});
    endtask

    task automatic slave_rsp(input logic [31:0] rdata, input logic err);
        acc_icb_rsp_valid = 1'b1;
        acc_icb_rsp_rdata = rdata;
        acc_icb_rsp_err   = err;
    endtask

    // Scoreboard monitor: sampled mid-cycle, so a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        logic [CW-1:0] ec;
        logic [RW-1:0] er;
        if (!rst && acc_icb_cmd_valid && acc_icb_cmd_ready) begin
            if (exp_cmd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL cmd_unexpected: actual=addr %0h required=no command", acc_icb_cmd_addr);
            end else begin
                ec = exp_cmd_q.pop_front();
                check("cmd", {req_cmd_ready, acc_icb_cmd_read, acc_icb_cmd_addr,
                              acc_icb_cmd_wdata, acc_icb_cmd_wmask}, ec);
            end
        end
        if (!rst && |(req_rsp_valid & req_rsp_ready)) begin
            if (exp_rsp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: actual=valid %0h required=no response", req_rsp_valid);
            end else begin
                er = exp_rsp_q.pop_front();
                check("rsp", {req_rsp_valid, req_rsp_err, req_rsp_rdata}, er);
            end
        end
        if (!rst && dut.lock_q) check("lock_hold_valid", req_cmd_valid[dut.locked_idx_q], 1);
    end

    // Stimulus
    initial begin
        logic [2:0] oh;
        rst               = 1'b1;
        req_cmd_valid     = 3'b111;
        req_cmd_read      = '0;
        req_cmd_addr      = '0;
        req_cmd_wdata     = '0;
        req_cmd_wmask     = '0;
        req_rsp_ready     = 3'b111;
        acc_icb_cmd_ready = 1'b1;
        acc_icb_rsp_valid = 1'b1;
        acc_icb_rsp_err   = 1'b0;
        acc_icb_rsp_rdata = '0;
`ifdef ACC_ICB_ARB_ERR_STICKY_EN
        err_clr           = 1'b0;
`endif

        // Reset: outputs quiet even with requests and a response pending
        repeat (3) begin
            step();
            @(negedge clk);
            check("rst_cmd_ready", req_cmd_ready, 0);
            check("rst_cmd_valid", acc_icb_cmd_valid, 0);
            check("rst_rsp_valid", req_rsp_valid, 0);
            check("rst_rsp_ready", acc_icb_rsp_ready, 1);
        end
        step();
        rst               = 1'b0;
        req_cmd_valid     = '0;
        acc_icb_rsp_valid = 1'b0;
        acc_icb_cmd_ready = 1'b0;
        @(negedge clk);
        check("idle_cmd_valid", acc_icb_cmd_valid, 0);
        check("idle_rsp_ready", acc_icb_rsp_ready, 1);
        check("idle_spurious", dut.spurious_q, 0);

        // Single requester read
        step();
        set_req(0, 1'b1, 32'h1000, 32'h0, 4'hF);
        acc_icb_cmd_ready = 1'b1;
        exp_cmd(3'b001, 1'b1, 32'h1000, 32'h0, 4'hF);
        @(negedge clk);
        check("t1_addr", acc_icb_cmd_addr, 32'h1000);
        check("t1_ready", req_cmd_ready, 3'b001);
        step();
        req_cmd_valid = '0;
        slave_rsp(32'hDEADBEEF, 1'b0);
        exp_rsp(3'b001, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        check("t1_rsp_valid", req_rsp_valid, 3'b001);
        check("t1_rdata", req_rsp_rdata, 32'hDEADBEEF);
        step();
        acc_icb_rsp_valid = 1'b0;
        @(negedge clk);
        check("t1_fifo_empty", dut.fifo_empty, 1);

        // Mid-operation reset returns rr_ptr to 0
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_rr_ptr", dut.rr_ptr_q, 0);

        // Round robin with all three requesting; slave answers one cycle behind
        step();
        set_req(0, 1'b1, 32'h2000, 32'h0, 4'hF);
        set_req(1, 1'b0, 32'h2100, 32'h11111111, 4'h3);
        set_req(2, 1'b1, 32'h2200, 32'h0, 4'hF);
        acc_icb_cmd_ready = 1'b1;
        repeat (2) begin
            exp_cmd(3'b001, 1'b1, 32'h2000, 32'h0, 4'hF);
            exp_cmd(3'b010, 1'b0, 32'h2100, 32'h11111111, 4'h3);
            exp_cmd(3'b100, 1'b1, 32'h2200, 32'h0, 4'hF);
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 6) req_cmd_valid = '0;
            slave_rsp(32'hA0 + k - 1, 1'b0);
            oh = 3'b001 << ((k - 1) % 3);
            exp_rsp(oh, 1'b0, 32'hA0 + k - 1);
        end
        step();
        acc_icb_rsp_valid = 1'b0;

        // Lock: req0 stalled for 3 cycles while req1 (next in rr order) appears
        step();
        set_req(0, 1'b1, 32'h3000, 32'h0, 4'hF);
        acc_icb_cmd_ready = 1'b1;
        exp_cmd(3'b001, 1'b1, 32'h3000, 32'h0, 4'hF);
        step();
        set_req(0, 1'b1, 32'h3004, 32'h0, 4'hF);
        acc_icb_cmd_ready = 1'b0;
        @(negedge clk);
        check("t3_valid", acc_icb_cmd_valid, 1);
        check("t3_addr0", acc_icb_cmd_addr, 32'h3004);
        check("t3_ready0", req_cmd_ready, 3'b000);
        step();
        set_req(1, 1'b0, 32'h3100, 32'h22222222, 4'hF);
        @(negedge clk);
        check("t3_addr1", acc_icb_cmd_addr, 32'h3004);
        check("t3_ready1", req_cmd_ready, 3'b000);
        step();
        @(negedge clk);
        check("t3_addr2", acc_icb_cmd_addr, 32'h3004);
        step();
        acc_icb_cmd_ready = 1'b1;
        exp_cmd(3'b001, 1'b1, 32'h3004, 32'h0, 4'hF);
        @(negedge clk);
        check("t3_ready_hs", req_cmd_ready, 3'b001);
        step();
        req_cmd_valid[0] = 1'b0;
        exp_cmd(3'b010, 1'b0, 32'h3100, 32'h22222222, 4'hF);
        @(negedge clk);
        check("t3_next_grant", req_cmd_ready, 3'b010);
        check("t3_next_addr", acc_icb_cmd_addr, 32'h3100);
        step();
        req_cmd_valid     = '0;
        acc_icb_cmd_ready = 1'b0;

        // Response stall: head (req0) not ready for 2 cycles
        step();
        slave_rsp(32'hB0, 1'b0);
        req_rsp_ready = 3'b110;
        @(negedge clk);
        check("t5_stall_rdy0", acc_icb_rsp_ready, 0);
        check("t5_stall_vld0", req_rsp_valid, 3'b001);
        step();
        @(negedge clk);
        check("t5_stall_rdy1", acc_icb_rsp_ready, 0);
        step();
        req_rsp_ready = 3'b111;
        exp_rsp(3'b001, 1'b0, 32'hB0);
        step();
        slave_rsp(32'hB1, 1'b0);
        exp_rsp(3'b001, 1'b0, 32'hB1);
        step();
        slave_rsp(32'hB2, 1'b0);
        exp_rsp(3'b010, 1'b0, 32'hB2);
        step();
        acc_icb_rsp_valid = 1'b0;

        // Spurious response with nothing outstanding
        step();
        slave_rsp(32'h5BAD, 1'b0);
        req_rsp_ready = 3'b000;
        @(negedge clk);
        check("spur_rsp_ready", acc_icb_rsp_ready, 1);
        check("spur_rsp_valid", req_rsp_valid, 3'b000);
        step();
        acc_icb_rsp_valid = 1'b0;
        req_rsp_ready     = 3'b111;
        @(negedge clk);
        check("spur_flag", dut.spurious_q, 1);
        check("spur_fifo_empty", dut.fifo_empty, 1);

        // FIFO full: four accepted, fifth blocked until a response is popped
        step();
        set_req(2, 1'b0, 32'h4000, 32'h44444444, 4'hF);
        acc_icb_cmd_ready = 1'b1;
        repeat (4) exp_cmd(3'b100, 1'b0, 32'h4000, 32'h44444444, 4'hF);
        repeat (4) step();
        @(negedge clk);
        check("t4_full_ready", req_cmd_ready, 3'b000);
        check("t4_full_valid", acc_icb_cmd_valid, 0);
        step();
        slave_rsp(32'hC0, 1'b0);
        exp_rsp(3'b100, 1'b0, 32'hC0);
        @(negedge clk);
        check("t4_no_bypass", req_cmd_ready, 3'b000);
        exp_cmd(3'b100, 1'b0, 32'h4000, 32'h44444444, 4'hF);
        step();
        acc_icb_rsp_valid = 1'b0;
        @(negedge clk);
        check("t4_fifth_ready", req_cmd_ready, 3'b100);
        step();
        req_cmd_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            slave_rsp(32'hC0 + k, k == 4);
            exp_rsp(3'b100, k == 4, 32'hC0 + k);
            step();
        end
        acc_icb_rsp_valid = 1'b0;
        acc_icb_rsp_err   = 1'b0;

`ifdef ACC_ICB_ARB_ERR_STICKY_EN
        // Sticky error: set by the req2 error above, cleared, then clear beats a same-cycle set
        @(negedge clk);
        check("sticky_set", req_err_sticky, 3'b100);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge clk);
        check("sticky_clr", req_err_sticky, 3'b000);
        step();
        set_req(2, 1'b1, 32'h5000, 32'h0, 4'hF);
        exp_cmd(3'b100, 1'b1, 32'h5000, 32'h0, 4'hF);
        step();
        req_cmd_valid = '0;
        slave_rsp(32'hD0, 1'b1);
        exp_rsp(3'b100, 1'b1, 32'hD0);
        err_clr = 1'b1;
        step();
        acc_icb_rsp_valid = 1'b0;
        acc_icb_rsp_err   = 1'b0;
        err_clr           = 1'b0;
        @(negedge clk);
        check("sticky_clr_wins", req_err_sticky, 3'b000);
`endif

        step();
        @(negedge clk);
        check("cmd_q_drained", exp_cmd_q.size(), 0);
        check("rsp_q_drained", exp_rsp_q.size(), 0);
        check("final_fifo_empty", dut.fifo_empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
